// File: rtl/irq_controller_pkg.sv
// Shared definitions for the external interrupt controller: register offsets,
// FSM state encoding and the fixed-priority winner encoder.
package irq_controller_pkg;

  localparam logic [3:0] IRQ_PENDING_OFS = 4'h0;
  localparam logic [3:0] IRQ_ENABLE_OFS  = 4'h4;
  localparam logic [3:0] IRQ_CLAIM_OFS   = 4'h8;
  localparam logic [3:0] IRQ_CONFIG_OFS  = 4'hC;

  localparam int unsigned IRQ_MAX_SRC = 31;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_WAIT   = 2'd2
  } irq_state_e;

  // Lowest set index wins; returns index+1, or 0 when nothing is active.
  function automatic logic [4:0] irq_winner_id(input logic [IRQ_MAX_SRC-1:0] act);
    logic [4:0] id;
    id = '0;
    for (int unsigned i = IRQ_MAX_SRC; i > 0; i--) begin
      if (act[i-1]) id = 5'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: optional two-flop synchronizer
// (IRQ_CONTROLLER_SYNC_EN), source sample flop, edge detect and pending bit.
module irq_gateway
  import irq_controller_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic src,
  input  logic edge_mode,
  input  logic w1c,
  input  logic claim_clr,
  output logic pending
);

  logic src_s;
  logic src_q;

`ifdef IRQ_CONTROLLER_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = src;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      src_q <= 1'b0;
    end else begin
      src_q <= src_s;
    end
  end

  // Level mode follows the sample flop; edge mode latches, and a new edge beats a clear.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pending <= 1'b0;
    end else if (!edge_mode) begin
      pending <= src_q;
    end else if (src_s && !src_q) begin
      pending <= 1'b1;
    end else if (w1c || claim_clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped external interrupt controller with claim/complete handshake.
// Define IRQ_CONTROLLER_SYNC_EN to add source synchronizers in each gateway.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               csb_i,
  input  logic               wen_i,
  input  logic [3:0]         addr_i,
  input  logic [31:0]        data_i,
  input  logic [3:0]         wmask_i,
  output logic [31:0]        data_o,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               irq_ack_i,
  output logic               meip_o
);

  irq_state_e         state_q, state_n;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] config_q;
  logic [4:0]         claim_q, claim_n;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] w1c_vec;
  logic [NUM_SRC-1:0] claim_clr;
  logic [4:0]         winner;
  logic               take;
  logic               complete;
  logic [31:0]        byte_mask;
  logic [NUM_SRC-1:0] wr_mask;
  logic [NUM_SRC-1:0] wr_data;
  logic [3:0]         reg_ofs;
  logic               wr;
  logic               unused_bits;

  assign reg_ofs   = {addr_i[3:2], 2'b00};
  assign wr        = !csb_i && !wen_i;
  assign byte_mask = {{8{wmask_i[3]}}, {8{wmask_i[2]}}, {8{wmask_i[1]}}, {8{wmask_i[0]}}};
  assign wr_mask   = byte_mask[NUM_SRC-1:0];
  assign wr_data   = data_i[NUM_SRC-1:0];
  assign w1c_vec   = (wr && reg_ofs == IRQ_PENDING_OFS) ? (wr_data & wr_mask) : '0;
  assign complete  = wr && reg_ofs == IRQ_CLAIM_OFS && wmask_i[0] && data_i[4:0] == claim_q;
  assign unused_bits = ^{addr_i[1:0], data_i};

  assign act    = pending & enable_q;
  assign winner = irq_winner_id(IRQ_MAX_SRC'(act));

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .src       (src_i[g]),
      .edge_mode (config_q[g]),
      .w1c       (w1c_vec[g]),
      .claim_clr (claim_clr[g]),
      .pending   (pending[g])
    );
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      enable_q <= '0;
      config_q <= '0;
    end else if (wr) begin
      if (reg_ofs == IRQ_ENABLE_OFS) enable_q <= (enable_q & ~wr_mask) | (wr_data & wr_mask);
      if (reg_ofs == IRQ_CONFIG_OFS) config_q <= (config_q & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  always_comb begin
    state_n = state_q;
    claim_n = claim_q;
    take    = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (|act) state_n = IRQ_ASSERT;
      end
      IRQ_ASSERT: begin
        if (irq_ack_i && |act) begin
          take    = 1'b1;
          claim_n = winner;
          state_n = IRQ_WAIT;
        end else if (!(|act)) begin
          state_n = IRQ_IDLE;
        end
      end
      IRQ_WAIT: begin
        if (complete) begin
          claim_n = '0;
          state_n = IRQ_IDLE;
        end
      end
      default: state_n = IRQ_IDLE;
    endcase
  end

  always_comb begin
    claim_clr = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      claim_clr[i] = take && (winner == 5'(i + 1));
    end
  end

  // meip_o is a registered copy of "next state is ASSERT".
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IRQ_IDLE;
      claim_q <= '0;
      meip_o  <= 1'b0;
    end else begin
      state_q <= state_n;
      claim_q <= claim_n;
      meip_o  <= (state_n == IRQ_ASSERT);
    end
  end

  always_comb begin
    data_o = '0;
    if (!csb_i) begin
      case (reg_ofs)
        IRQ_PENDING_OFS: data_o = 32'(pending);
        IRQ_ENABLE_OFS:  data_o = 32'(enable_q);
        IRQ_CLAIM_OFS:   data_o = 32'(claim_q);
        IRQ_CONFIG_OFS:  data_o = 32'(config_q);
        default:         data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (NUM_SRC=8); honours
// IRQ_CONTROLLER_SYNC_EN by adding the synchronizer delay to source timing.
module tb_irq_controller;

  localparam int N = 8;
`ifdef IRQ_CONTROLLER_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b0;
  logic         csb_i = 1'b1;
  logic         wen_i = 1'b1;
  logic [3:0]   addr_i = '0;
  logic [31:0]  data_i = '0;
  logic [3:0]   wmask_i = '0;
  logic [31:0]  data_o;
  logic [N-1:0] src_i = '0;
  logic         irq_ack_i = 1'b0;
  logic         meip_o;

  int total = 0;
  int bad = 0;

  irq_controller #(.NUM_SRC(N)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .csb_i     (csb_i),
    .wen_i     (wen_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .wmask_i   (wmask_i),
    .data_o    (data_o),
    .src_i     (src_i),
    .irq_ack_i (irq_ack_i),
    .meip_o    (meip_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb_i = 1'b0; wen_i = 1'b0; addr_i = a; data_i = d; wmask_i = m;
    tick();
    csb_i = 1'b1; wen_i = 1'b1; wmask_i = '0; data_i = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    csb_i = 1'b0; wen_i = 1'b1; addr_i = a;
    #1;
    d = data_o;
    csb_i = 1'b1;
  endtask

  task automatic ack_pulse();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_i = 1'b0;
    repeat (3) tick();
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL rst_meip got=%b exp=0", meip_o); end
    total++; if (data_o !== 32'h0) begin bad++; $display("FAIL rst_idle_bus got=%h exp=0", data_o); end
    reset_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i * 4), rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_reg%0d got=%h exp=0", i, rd); end
    end
    ack_pulse();
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL idle_ack_claim got=%h exp=0", rd); end
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL idle_ack_meip got=%b exp=0", meip_o); end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    bus_write(4'h4, 32'hFFFF_FFFF, 4'hF);
    bus_read(4'h4, rd);
    total++; if (rd !== 32'h0000_00FF) begin bad++; $display("FAIL enable_width got=%h exp=000000ff", rd); end
    bus_write(4'h4, 32'h0, 4'h2);
    bus_read(4'h4, rd);
    total++; if (rd !== 32'h0000_00FF) begin bad++; $display("FAIL enable_mask_off got=%h exp=000000ff", rd); end
    bus_write(4'h4, 32'h0, 4'h1);
    bus_read(4'h4, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL enable_mask_on got=%h exp=0", rd); end
    bus_write(4'hC, 32'h0000_01A5, 4'hF);
    bus_read(4'hC, rd);
    total++; if (rd !== 32'h0000_00A5) begin bad++; $display("FAIL config_rw got=%h exp=000000a5", rd); end
    bus_write(4'hC, 32'h0, 4'hF);
  endtask

  task automatic test_edge();
    logic [31:0] rd;
    bus_write(4'h4, 32'h04, 4'hF);
    bus_write(4'hC, 32'h04, 4'hF);
    src_i = 8'h04;
    tick();
    src_i = 8'h00;
    repeat (SD) tick();
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h04) begin bad++; $display("FAIL edge_pending got=%h exp=4", rd); end
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL edge_meip_early got=%b exp=0", meip_o); end
    tick();
    total++; if (meip_o !== 1'b1) begin bad++; $display("FAIL edge_meip got=%b exp=1", meip_o); end
    ack_pulse();
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL edge_claim got=%h exp=3", rd); end
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL edge_claim_clr got=%h exp=0", rd); end
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL edge_ack_meip got=%b exp=0", meip_o); end
    bus_write(4'h8, 32'h3, 4'hF);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL edge_complete got=%h exp=0", rd); end
    tick();
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL edge_after_meip got=%b exp=0", meip_o); end
  endtask

  task automatic test_level();
    logic [31:0] rd;
    bus_write(4'hC, 32'h00, 4'hF);
    bus_write(4'h4, 32'hFF, 4'hF);
    src_i = 8'h22;
    repeat (2 + SD) tick();
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h22) begin bad++; $display("FAIL lvl_pending got=%h exp=22", rd); end
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL lvl_meip_early got=%b exp=0", meip_o); end
    tick();
    total++; if (meip_o !== 1'b1) begin bad++; $display("FAIL lvl_meip got=%b exp=1", meip_o); end
    ack_pulse();
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL lvl_claim1 got=%h exp=2", rd); end
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h22) begin bad++; $display("FAIL lvl_not_latched got=%h exp=22", rd); end
    bus_write(4'h8, 32'h2, 4'h1);
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL lvl_cmpl_meip got=%b exp=0", meip_o); end
    tick();
    total++; if (meip_o !== 1'b1) begin bad++; $display("FAIL lvl_rereq got=%b exp=1", meip_o); end
    ack_pulse();
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL lvl_claim2 got=%h exp=2", rd); end
    src_i = 8'h20;
    repeat (SD) tick();
    bus_write(4'h8, 32'h2, 4'h1);
    tick();
    total++; if (meip_o !== 1'b1) begin bad++; $display("FAIL lvl_rereq2 got=%b exp=1", meip_o); end
    ack_pulse();
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h6) begin bad++; $display("FAIL lvl_claim3 got=%h exp=6", rd); end
    bus_write(4'h4, 32'h00, 4'hF);
    src_i = 8'h00;
    repeat (2 + SD) tick();
    bus_write(4'h8, 32'h6, 4'h1);
    repeat (3) tick();
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL lvl_final_claim got=%h exp=0", rd); end
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL lvl_final_meip got=%b exp=0", meip_o); end
  endtask

  task automatic test_claim_mismatch();
    logic [31:0] rd;
    bus_write(4'hC, 32'h04, 4'hF);
    bus_write(4'h4, 32'h04, 4'hF);
    src_i = 8'h04;
    tick();
    src_i = 8'h00;
    repeat (SD + 1) tick();
    total++; if (meip_o !== 1'b1) begin bad++; $display("FAIL mm_meip got=%b exp=1", meip_o); end
    ack_pulse();
    bus_write(4'h8, 32'h5, 4'hF);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL mm_wrong_id got=%h exp=3", rd); end
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL mm_wait_meip got=%b exp=0", meip_o); end
    bus_write(4'h8, 32'h3, 4'hE);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL mm_no_byte0 got=%h exp=3", rd); end
    tick();
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL mm_wait_hold got=%b exp=0", meip_o); end
    bus_write(4'h8, 32'h3, 4'h1);
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mm_complete got=%h exp=0", rd); end
  endtask

  task automatic test_enable_w1c();
    logic [31:0] rd;
    src_i = 8'h04;
    tick();
    src_i = 8'h00;
    repeat (SD + 1) tick();
    total++; if (meip_o !== 1'b1) begin bad++; $display("FAIL ew_meip got=%b exp=1", meip_o); end
    bus_write(4'h4, 32'h00, 4'hF);
    total++; if (meip_o !== 1'b1) begin bad++; $display("FAIL ew_meip_hold got=%b exp=1", meip_o); end
    tick();
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL ew_meip_drop got=%b exp=0", meip_o); end
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h04) begin bad++; $display("FAIL ew_retained got=%h exp=4", rd); end
    bus_write(4'h0, 32'h04, 4'hF);
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL ew_w1c got=%h exp=0", rd); end
    src_i = 8'h04;
    repeat (SD) tick();
    bus_write(4'h0, 32'h04, 4'hF);
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h04) begin bad++; $display("FAIL ew_set_wins got=%h exp=4", rd); end
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL ew_masked_meip got=%b exp=0", meip_o); end
    src_i = 8'h00;
    repeat (SD + 1) tick();
    bus_write(4'h0, 32'h04, 4'hF);
    bus_read(4'h0, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL ew_w1c2 got=%h exp=0", rd); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    bus_write(4'h4, 32'h04, 4'hF);
    src_i = 8'h04;
    tick();
    src_i = 8'h00;
    repeat (SD + 1) tick();
    ack_pulse();
    bus_read(4'h8, rd);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL ar_claim got=%h exp=3", rd); end
    #1;
    reset_i = 1'b0;
    #1;
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL ar_meip got=%b exp=0", meip_o); end
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i * 4), rd);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL ar_reg%0d got=%h exp=0", i, rd); end
    end
    tick();
    reset_i = 1'b1;
    tick();
    total++; if (meip_o !== 1'b0) begin bad++; $display("FAIL ar_post_meip got=%b exp=0", meip_o); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_edge();
    test_level();
    test_claim_mismatch();
    test_enable_w1c();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
